// File: rtl/msx_vdp_pkg.sv
// Shared constants and types for the VDP CPU port: register indices,
// display mode encodings, status bit positions and prefetch FSM states.
package msx_vdp_pkg;

  localparam int PTR_W = 14;

  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;
  localparam logic [2:0] REG_R4 = 3'd4;
  localparam logic [2:0] REG_R5 = 3'd5;
  localparam logic [2:0] REG_R6 = 3'd6;
  localparam logic [2:0] REG_R7 = 3'd7;

  typedef enum logic [1:0] {
    MODE_TEXT = 2'd0,
    MODE_G1   = 2'd1,
    MODE_G2   = 2'd2,
    MODE_MC   = 2'd3
  } mode_e;

  localparam int ST_F  = 7;
  localparam int ST_5S = 6;
  localparam int ST_C  = 5;

  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_REQ  = 2'd1,
    PF_WAIT = 2'd2
  } pf_state_e;

endpackage

// File: rtl/vdp_regfile.sv
// VDP control registers R0-R7 and their decode into video-stage configuration.
// Writes take effect on the clock edge; decoded outputs follow combinationally.
module vdp_regfile
  import msx_vdp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  idx,
  input  logic [7:0]  wdata,
  output logic [1:0]  mode,
  output logic        video_on,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic        vert_retrace_int
);

  logic [7:0] regs [8];
  mode_e      mode_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[idx] <= wdata;
    end
  end

  // Text mode overrides everything; graphics II beats multicolor.
  always_comb begin
    mode_sel = MODE_G1;
    if (regs[REG_R1][4])      mode_sel = MODE_TEXT;
    else if (regs[REG_R0][1]) mode_sel = MODE_G2;
    else if (regs[REG_R1][3]) mode_sel = MODE_MC;
  end

  assign mode                      = mode_sel;
  assign video_on                  = regs[REG_R1][6];
  assign vert_retrace_int          = regs[REG_R1][5];
  assign sprite_large              = regs[REG_R1][1];
  assign sprite_enlarged           = regs[REG_R1][0];
  assign name_table_addr           = {regs[REG_R2][3:0], 10'b0};
  assign color_table_addr          = {regs[REG_R3], 6'b0};
  assign font_addr                 = {regs[REG_R4][2:0], 11'b0};
  assign sprite_attr_addr          = {regs[REG_R5][6:0], 7'b0};
  assign sprite_pattern_table_addr = {regs[REG_R6][2:0], 11'b0};
  assign text_color                = regs[REG_R7][7:4];
  assign back_color                = regs[REG_R7][3:0];

endmodule

// File: rtl/vdp_port.sv
// VDP CPU port: two-byte control protocol, VRAM pointer with read-ahead prefetch,
// status register with interrupt output. Strobes arriving while a prefetch runs are dropped.
module vdp_port
  import msx_vdp_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_a0,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_wr,
  output logic              vram_rd,
  output logic [7:0]        vram_dout,
  input  logic [7:0]        vram_din,
  output logic [1:0]        mode,
  output logic              video_on,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic              vert_retrace_int,
  input  logic              interrupt_flag,
  input  logic              sprite_collision,
  input  logic              too_many_sprites,
  input  logic [4:0]        sprite5,
  output logic              n_int
);

  logic [1:0]       rst_sync;
  logic             rst_n;
  pf_state_e        state;
  logic             flag;
  logic [7:0]       latch;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       buffer;
  logic             f, c, s5, int_d;
  logic [4:0]       spr5;
  logic [7:0]       status_byte;
  logic             acc_rd, acc_wr, stat_rd, reg_we;
  logic             int_rise, s5_set, f_next, c_next, s5_next;
  logic [PTR_W-1:0] ctrl_ptr;

  // Assert immediately, release two edges after n_reset rises.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign acc_wr   = cpu_wr & (state == PF_IDLE);
  assign acc_rd   = cpu_rd & ~cpu_wr & (state == PF_IDLE);
  assign stat_rd  = acc_rd & cpu_a0;
  assign reg_we   = acc_wr & cpu_a0 & flag & cpu_din[7];
  assign ctrl_ptr = {cpu_din[5:0], latch};

  // Set events win over the read-clear so no event is lost.
  assign int_rise = interrupt_flag & ~int_d;
  assign s5_set   = too_many_sprites & ~s5;
  assign f_next   = int_rise | (f & ~stat_rd);
  assign c_next   = sprite_collision | (c & ~stat_rd);
  assign s5_next  = s5_set | (s5 & ~stat_rd);

  always_comb begin
    status_byte        = {3'b000, spr5};
    status_byte[ST_F]  = f;
    status_byte[ST_5S] = s5;
    status_byte[ST_C]  = c;
  end

  assign cpu_dout = acc_rd ? (cpu_a0 ? status_byte : buffer) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PF_IDLE;
      flag      <= 1'b0;
      latch     <= 8'h00;
      ptr       <= '0;
      buffer    <= 8'h00;
      f         <= 1'b0;
      c         <= 1'b0;
      s5        <= 1'b0;
      spr5      <= 5'd0;
      int_d     <= 1'b0;
      n_int     <= 1'b1;
      vram_wr   <= 1'b0;
      vram_rd   <= 1'b0;
      vram_addr <= '0;
      vram_dout <= 8'h00;
    end else begin
      vram_wr <= 1'b0;
      int_d   <= interrupt_flag;
      f       <= f_next;
      c       <= c_next;
      s5      <= s5_next;
      if (s5_set) spr5 <= sprite5;
      n_int   <= ~(f_next & vert_retrace_int);
      case (state)
        PF_IDLE: begin
          if (acc_wr && cpu_a0) begin
            if (!flag) begin
              latch <= cpu_din;
              flag  <= 1'b1;
            end else begin
              flag <= 1'b0;
              if (!cpu_din[7]) begin
                ptr <= ctrl_ptr;
                if (!cpu_din[6]) begin
                  state     <= PF_REQ;
                  vram_rd   <= 1'b1;
                  vram_addr <= ADDR_W'(ctrl_ptr);
                end
              end
            end
          end else if (acc_wr) begin
            vram_wr   <= 1'b1;
            vram_addr <= ADDR_W'(ptr);
            vram_dout <= cpu_din;
            buffer    <= cpu_din;
            ptr       <= ptr + 1'b1;
            flag      <= 1'b0;
          end else if (acc_rd) begin
            flag <= 1'b0;
            if (!cpu_a0) begin
              state     <= PF_REQ;
              vram_rd   <= 1'b1;
              vram_addr <= ADDR_W'(ptr);
            end
          end
        end
        PF_REQ: begin
          vram_rd <= 1'b0;
          state   <= PF_WAIT;
        end
        PF_WAIT: begin
          buffer <= vram_din;
          ptr    <= ptr + 1'b1;
          state  <= PF_IDLE;
        end
        default: state <= PF_IDLE;
      endcase
    end
  end

  vdp_regfile u_regfile (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .we                        (reg_we),
    .idx                       (cpu_din[2:0]),
    .wdata                     (latch),
    .mode                      (mode),
    .video_on                  (video_on),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .text_color                (text_color),
    .back_color                (back_color),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .vert_retrace_int          (vert_retrace_int)
  );

endmodule

// File: tb/tb_vdp_port.sv
// Directed bench for vdp_port with a behavioural VRAM and strobe-spacing monitor.
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_a0 = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic [13:0] vram_addr;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_dout;
  logic [7:0]  vram_din = 8'h00;
  logic [1:0]  mode;
  logic        video_on;
  logic [13:0] name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr;
  logic [3:0]  text_color, back_color;
  logic        sprite_large, sprite_enlarged, vert_retrace_int;
  logic        interrupt_flag = 1'b0, sprite_collision = 1'b0, too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = 5'd0;
  logic        n_int;

  int checks = 0;
  int errors = 0;
  int proto_errs = 0;
  int gap = 8;

  bit   [7:0]  mem [0:16383];
  logic [13:0] last_wr_addr = '0;
  logic [13:0] last_rd_addr = '0;

  always #5 clk = ~clk;

  vdp_port #(.ADDR_W(14)) dut (
    .clk(clk), .n_reset(n_reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a0(cpu_a0),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_addr(vram_addr), .vram_wr(vram_wr),
    .vram_rd(vram_rd), .vram_dout(vram_dout), .vram_din(vram_din), .mode(mode),
    .video_on(video_on), .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
    .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr), .text_color(text_color),
    .back_color(back_color), .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
    .vert_retrace_int(vert_retrace_int), .interrupt_flag(interrupt_flag),
    .sprite_collision(sprite_collision), .too_many_sprites(too_many_sprites),
    .sprite5(sprite5), .n_int(n_int)
  );

  // VRAM: writes land on the edge, read data appears one cycle after vram_rd.
  always @(posedge clk) begin
    if (vram_wr) begin
      mem[vram_addr] <= vram_dout;
      last_wr_addr   <= vram_addr;
    end
    if (vram_rd) begin
      vram_din     <= mem[vram_addr];
      last_rd_addr <= vram_addr;
    end
  end

  // Strobes closer than 3 clocks apart are a bus protocol error.
  always @(posedge clk) begin
    if (n_reset && (cpu_rd || cpu_wr)) begin
      if (gap < 3) begin
        $display("FAIL protocol: strobe spacing %0d clocks, required >= 3", gap);
        proto_errs <= proto_errs + 1;
      end
      gap <= 1;
    end else if (gap < 255) begin
      gap <= gap + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpu_access(input logic rd, input logic a0, input logic [7:0] d, output logic [7:0] q);
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = ~rd; cpu_a0 = a0; cpu_din = d;
    @(negedge clk);
    q = cpu_dout;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    logic [7:0] q;
    cpu_access(1'b0, 1'b1, d, q);
  endtask

  task automatic data_wr(input logic [7:0] d);
    logic [7:0] q;
    cpu_access(1'b0, 1'b0, d, q);
  endtask

  task automatic data_rd(output logic [7:0] q);
    cpu_access(1'b1, 1'b0, 8'h00, q);
  endtask

  task automatic stat_rd(output logic [7:0] q);
    cpu_access(1'b1, 1'b1, 8'h00, q);
  endtask

  task automatic test_reset;
    logic [7:0] q;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (vram_wr !== 1'b0 || vram_rd !== 1'b0) begin errors++; $display("FAIL reset_vram: wr=%b rd=%b, required 0 0", vram_wr, vram_rd); end
    checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL reset_n_int: got %b, required 1", n_int); end
    checks++; if (mode !== 2'd1 || video_on !== 1'b0) begin errors++; $display("FAIL reset_mode: mode=%0d video_on=%b, required 1 0", mode, video_on); end
    checks++; if (cpu_dout !== 8'h00 || name_table_addr !== 14'h0 || back_color !== 4'h0) begin errors++; $display("FAIL reset_outputs: dout=%h nt=%h bc=%h, required 00 0000 0", cpu_dout, name_table_addr, back_color); end
    @(posedge clk); #1 n_reset = 1'b1;
    repeat (4) @(posedge clk);
    stat_rd(q);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_status: got %h, required 00", q); end
  endtask

  task automatic test_data_write;
    logic [7:0] q;
    ctrl_wr(8'h00); ctrl_wr(8'h40);
    data_wr(8'h11);
    checks++; if (last_wr_addr !== 14'h0000) begin errors++; $display("FAIL wr1_addr: got %h, required 0000", last_wr_addr); end
    data_wr(8'h22);
    checks++; if (last_wr_addr !== 14'h0001) begin errors++; $display("FAIL wr2_addr: got %h, required 0001", last_wr_addr); end
    checks++; if (mem[0] !== 8'h11 || mem[1] !== 8'h22) begin errors++; $display("FAIL wr_data: vram0=%h vram1=%h, required 11 22", mem[0], mem[1]); end
    data_rd(q);
    checks++; if (q !== 8'h22) begin errors++; $display("FAIL wr_buffer: got %h, required 22", q); end
    checks++; if (last_rd_addr !== 14'h0002) begin errors++; $display("FAIL wr_pointer: prefetch addr %h, required 0002", last_rd_addr); end
  endtask

  task automatic test_regs;
    ctrl_wr(8'h12); ctrl_wr(8'h87);
    checks++; if (back_color !== 4'h2 || text_color !== 4'h1) begin errors++; $display("FAIL r7_colors: back=%h text=%h, required 2 1", back_color, text_color); end
    ctrl_wr(8'h06); ctrl_wr(8'h82);
    checks++; if (name_table_addr !== 14'h1800) begin errors++; $display("FAIL r2_name_table: got %h, required 1800", name_table_addr); end
    ctrl_wr(8'hFF); ctrl_wr(8'h83);
    checks++; if (color_table_addr !== 14'h3FC0) begin errors++; $display("FAIL r3_color_table: got %h, required 3fc0", color_table_addr); end
    ctrl_wr(8'h02); ctrl_wr(8'h80);
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL mode_g2: got %0d, required 2", mode); end
    ctrl_wr(8'h18); ctrl_wr(8'h81);
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL mode_text: got %0d, required 0", mode); end
    ctrl_wr(8'h08); ctrl_wr(8'h81);
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL mode_g2_over_mc: got %0d, required 2", mode); end
    ctrl_wr(8'h00); ctrl_wr(8'h80);
    checks++; if (mode !== 2'd3) begin errors++; $display("FAIL mode_mc: got %0d, required 3", mode); end
  endtask

  task automatic test_wrap;
    logic [7:0] q;
    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    data_wr(8'hAB);
    checks++; if (last_wr_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap_wr_addr: got %h, required 3fff", last_wr_addr); end
    data_wr(8'hCD);
    checks++; if (last_wr_addr !== 14'h0000) begin errors++; $display("FAIL wrap_wr_wrap: got %h, required 0000", last_wr_addr); end
    ctrl_wr(8'hFF); ctrl_wr(8'h3F);
    data_rd(q);
    checks++; if (q !== 8'hAB) begin errors++; $display("FAIL wrap_rd1: got %h, required ab", q); end
    data_rd(q);
    checks++; if (q !== 8'hCD) begin errors++; $display("FAIL wrap_rd2: got %h, required cd", q); end
    checks++; if (last_rd_addr !== 14'h0001) begin errors++; $display("FAIL wrap_pointer: got %h, required 0001", last_rd_addr); end
  endtask

  task automatic test_interrupt;
    logic [7:0] q;
    ctrl_wr(8'h20); ctrl_wr(8'h81);
    checks++; if (vert_retrace_int !== 1'b1 || n_int !== 1'b1) begin errors++; $display("FAIL int_enable: vri=%b n_int=%b, required 1 1", vert_retrace_int, n_int); end
    @(posedge clk); #1 interrupt_flag = 1'b1;
    @(posedge clk); #1 interrupt_flag = 1'b0;
    @(negedge clk);
    checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL int_assert: n_int=%b, required 0", n_int); end
    @(posedge clk); #1 cpu_rd = 1'b1; cpu_a0 = 1'b1;
    @(negedge clk); q = cpu_dout;
    checks++; if (q !== 8'h80) begin errors++; $display("FAIL int_status: got %h, required 80", q); end
    @(posedge clk); #1 cpu_rd = 1'b0;
    @(negedge clk);
    checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL int_release: n_int=%b, required 1", n_int); end
    checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL idle_dout: got %h, required 00", cpu_dout); end
    repeat (3) @(posedge clk);
    stat_rd(q);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL int_cleared: got %h, required 00", q); end
  endtask

  task automatic test_status_bits;
    logic [7:0] q;
    @(posedge clk); #1 sprite_collision = 1'b1; too_many_sprites = 1'b1; sprite5 = 5'h13;
    @(posedge clk); #1 sprite_collision = 1'b0; too_many_sprites = 1'b0;
    @(posedge clk); #1 too_many_sprites = 1'b1; sprite5 = 5'h07;
    @(posedge clk); #1 too_many_sprites = 1'b0;
    stat_rd(q);
    checks++; if (q !== 8'h73) begin errors++; $display("FAIL status_5s_c: got %h, required 73", q); end
    stat_rd(q);
    checks++; if (q !== 8'h13) begin errors++; $display("FAIL status_cleared: got %h, required 13", q); end
    @(posedge clk); #1 cpu_rd = 1'b1; cpu_a0 = 1'b1; sprite_collision = 1'b1;
    @(negedge clk); q = cpu_dout;
    checks++; if (q !== 8'h13) begin errors++; $display("FAIL set_wins_old: got %h, required 13", q); end
    @(posedge clk); #1 cpu_rd = 1'b0; sprite_collision = 1'b0;
    repeat (3) @(posedge clk);
    stat_rd(q);
    checks++; if (q !== 8'h33) begin errors++; $display("FAIL set_wins_kept: got %h, required 33", q); end
  endtask

  task automatic test_stale_latch;
    logic [7:0] q;
    ctrl_wr(8'h55);
    stat_rd(q);
    ctrl_wr(8'h00); ctrl_wr(8'h40);
    data_wr(8'h5A);
    checks++; if (last_wr_addr !== 14'h0000 || mem[0] !== 8'h5A) begin errors++; $display("FAIL stale_latch: addr=%h vram0=%h, required 0000 5a", last_wr_addr, mem[0]); end
  endtask

  task automatic test_reset_prefetch;
    logic [7:0] q;
    ctrl_wr(8'h00);
    @(posedge clk); #1 cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_din = 8'h00;
    @(posedge clk); #1 cpu_wr = 1'b0;
    @(posedge clk); #1 n_reset = 1'b0;
    #1;
    checks++; if (vram_rd !== 1'b0 || vram_wr !== 1'b0 || n_int !== 1'b1) begin errors++; $display("FAIL rst_wait_bus: rd=%b wr=%b n_int=%b, required 0 0 1", vram_rd, vram_wr, n_int); end
    checks++; if (mode !== 2'd1 || video_on !== 1'b0 || vert_retrace_int !== 1'b0 || back_color !== 4'h0) begin errors++; $display("FAIL rst_wait_cfg: mode=%0d von=%b vri=%b bc=%h, required 1 0 0 0", mode, video_on, vert_retrace_int, back_color); end
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    repeat (4) @(posedge clk);
    data_rd(q);
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_wait_buffer: got %h, required 00", q); end
    data_rd(q);
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL rst_fsm_idle: got %h, required 5a", q); end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_regs();
    test_wrap();
    test_interrupt();
    test_status_bits();
    test_stale_latch();
    test_reset_prefetch();
    checks++; if (proto_errs !== 0) begin errors++; $display("FAIL protocol_total: got %0d violations, required 0", proto_errs); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
